// File: rtl/rb_arb_pkg.sv
// Shared definitions for the register-bank port arbiter.
//   state_e          : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   REQ_OP1/OP2/WB   : requester slot assignment on the request vectors
//   idx_w()          : width of a binary index into n requesters (at least 1)
package rb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int REQ_OP1 = 0;
  localparam int REQ_OP2 = 1;
  localparam int REQ_WB  = 2;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_port_arbiter_if.sv
// Requester and register-bank signal bundle for rb_port_arbiter.
//   req_valid/req_we/req_addr/req_wdata : flattened per-requester requests
//   req_grant/resp_valid                : one-hot pulses back to requesters
//   resp_data/resp_err                  : completion payload
//   rb_valid/rb_we/rb_addr/rb_wdata     : request to the register bank
//   rb_ready/rb_rdata                   : completion from the register bank
// master = the arbiter, slave = requesters plus register bank.
interface rb_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;
  logic                      rb_valid;
  logic                      rb_we;
  logic [ADDR_W-1:0]         rb_addr;
  logic [DATA_W-1:0]         rb_wdata;
  logic                      rb_ready;
  logic [DATA_W-1:0]         rb_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rb_ready, rb_rdata,
    output req_grant, resp_valid, resp_data, resp_err,
           rb_valid, rb_we, rb_addr, rb_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rb_ready, rb_rdata,
    input  req_grant, resp_valid, resp_data, resp_err,
           rb_valid, rb_we, rb_addr, rb_wdata
  );
endinterface

// File: rtl/rb_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   : request vector
//   ptr   : highest-priority index this round (must be < N)
//   grant : one-hot winner (0 when nothing requests)
//   idx   : binary winner index
//   found : any request present
module rr_pick
  import rb_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W:0] slot;

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise paths that skip an assignment infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    slot  = '0;
    // Scan upward from ptr; one conditional subtract wraps modulo N.
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (slot >= (IDX_W + 1)'(N)) slot = slot - (IDX_W + 1)'(N);
      if (!found && req[slot[IDX_W-1:0]]) begin
        found                    = 1'b1;
        idx                      = slot[IDX_W-1:0];
        grant[slot[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rb_port_arbiter.sv
// rb_port_arbiter: shares the single register-bank port between pipeline
// requesters with round-robin grant and one transaction in flight.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, abandons any transaction silently
//   bus   : requester and register-bank handshakes (see rb_port_arbiter_if)
//   busy  : high whenever the arbiter is not idle
module rb_port_arbiter
  import rb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  rb_port_arbiter_if.master   bus,
  output logic                busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, idx_q, pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot, grant_q;
  logic                 pick_found;
  logic [CNT_W-1:0]     cnt_q;
  logic                 timeout_hit;
  logic                 rb_valid_q, rb_we_q, err_q;
  logic [ADDR_W-1:0]    rb_addr_q;
  logic [DATA_W-1:0]    rb_wdata_q, data_q;
  logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Counter starts at 0 on the first BUSY cycle, so rb_valid stays up for
  // exactly TIMEOUT cycles before the abort.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_found) state_d = S_BUSY;
      S_BUSY:  if (bus.rb_ready || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too (they are flops, not a
      // memory) because every output must read 0 out of reset.
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      rb_valid_q <= 1'b0;
      rb_we_q    <= 1'b0;
      rb_addr_q  <= '0;
      rb_wdata_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q    <= pick_onehot;
            idx_q      <= pick_idx;
            rb_valid_q <= 1'b1;
            rb_we_q    <= bus.req_we[pick_idx];
            rb_addr_q  <= addr_arr[pick_idx];
            rb_wdata_q <= wdata_arr[pick_idx];
            cnt_q      <= '0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // rb_ready is tested first so it wins over a same-cycle timeout.
          if (bus.rb_ready) begin
            rb_valid_q <= 1'b0;
            data_q     <= rb_we_q ? '0 : bus.rb_rdata;
            err_q      <= 1'b0;
          end else if (timeout_hit) begin
            rb_valid_q <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b1;
          end
        end
        S_RESP: begin
          ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Response payload is gated so it reads 0 outside the RESP pulse.
  assign busy           = (state_q != S_IDLE);
  assign bus.req_grant  = grant_q;
  assign bus.resp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << idx_q) : '0;
  assign bus.resp_data  = (state_q == S_RESP) ? data_q : '0;
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign bus.rb_valid   = rb_valid_q;
  assign bus.rb_we      = rb_we_q;
  assign bus.rb_addr    = rb_addr_q;
  assign bus.rb_wdata   = rb_wdata_q;

endmodule

// File: tb/tb_rb_port_arbiter.sv
module tb_rb_port_arbiter;
  import rb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_cmp  = 0;
  int   n_fail = 0;

  rb_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifc ();

  rb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  rv;
    logic [2:0]  we;
    logic [11:0] addr;
    logic [95:0] wdata;
    int          delay;
    logic [31:0] rdata;
    bit          drop;
    logic [2:0]  e_grant;
    logic [3:0]  e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs [7];
  int   mptr;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // BUSY cycles the bank sees: ready offered at BUSY cycle `delay` (0-based)
  // or the timeout closes it after TO cycles, whichever comes first.
  function automatic int busy_cycles(input int delay);
    return (delay < TO) ? delay + 1 : TO;
  endfunction

  task automatic idle_inputs();
    ifc.req_valid = '0;
    ifc.req_we    = '0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.rb_ready  = 1'b0;
    ifc.rb_rdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One full transaction from IDLE: request, grant, bank handshake, response.
  task automatic run_txn(input string tag, input vec_t v);
    int lat, vcyc;
    bit got;
    ifc.req_valid = v.rv;
    ifc.req_we    = v.we;
    ifc.req_addr  = v.addr;
    ifc.req_wdata = v.wdata;
    ifc.rb_ready  = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (ifc.req_grant != '0) got = 1'b1;
    end
    check({tag, ".grant"}, ifc.req_grant, v.e_grant);
    if (!got) begin
      idle_inputs();
      return;
    end
    check({tag, ".rb_valid"}, ifc.rb_valid, 1'b1);
    check({tag, ".rb_addr"},  ifc.rb_addr,  v.e_addr);
    check({tag, ".rb_we"},    ifc.rb_we,    v.e_we);
    check({tag, ".rb_wdata"}, ifc.rb_wdata, v.e_wdata);
    if (v.drop) ifc.req_valid = '0;
    vcyc = 0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (ifc.rb_valid) vcyc++;
      ifc.rb_ready = (c == v.delay);
      ifc.rb_rdata = (c == v.delay) ? v.rdata : $urandom;
      @(posedge clk); #1;
      lat++;
      if (ifc.resp_valid != '0) got = 1'b1;
    end
    ifc.rb_ready  = 1'b0;
    ifc.req_valid = '0;
    check({tag, ".resp_valid"}, ifc.resp_valid, v.e_grant);
    check({tag, ".resp_data"},  ifc.resp_data,  v.e_data);
    check({tag, ".resp_err"},   ifc.resp_err,   v.e_err);
    check({tag, ".rb_valid_cycles"}, vcyc, busy_cycles(v.delay));
    check({tag, ".latency"}, lat, 1 + busy_cycles(v.delay));
    @(posedge clk); #1;
    check({tag, ".resp_pulse_end"}, ifc.resp_valid, 3'b000);
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    int   cyc, last, exp_i, idx, sc;
    bit   got;

    // Hand-computed vectors; pointer starts at 0 after reset and each row
    // assumes the pointer left by the row before it.
    vecs[0] = '{3'b001, 3'b000, 12'h005, 96'h0, 1, 32'hDEADBEEF, 1'b0,
                3'b001, 4'd5, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{3'b100, 3'b100, 12'hF00, {32'h12345678, 64'h0}, 0, 32'hCAFEF00D, 1'b0,
                3'b100, 4'd15, 1'b1, 32'h12345678, 32'h0, 1'b0};
    vecs[2] = '{3'b010, 3'b000, 12'h070, {32'h0, 32'h55, 32'h0}, 99, 32'h0000BEEF, 1'b0,
                3'b010, 4'd7, 1'b0, 32'h55, 32'h0, 1'b1};
    vecs[3] = '{3'b010, 3'b000, 12'h070, 96'h0, 3, 32'hA5A5A5A5, 1'b0,
                3'b010, 4'd7, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0};
    vecs[4] = '{3'b111, 3'b000, 12'h923, {32'h3, 32'h2, 32'h1}, 0, 32'h11112222, 1'b0,
                3'b100, 4'd9, 1'b0, 32'h3, 32'h11112222, 1'b0};
    vecs[5] = '{3'b011, 3'b000, 12'h923, {32'h3, 32'h2, 32'h1}, 2, 32'h0BADF00D, 1'b0,
                3'b001, 4'd3, 1'b0, 32'h1, 32'h0BADF00D, 1'b0};
    vecs[6] = '{3'b101, 3'b101, 12'h0A3, {32'hFFFFFFFF, 32'h2, 32'h1}, 2, 32'h77777777, 1'b0,
                3'b100, 4'd0, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0};

    do_reset();
    check("reset.busy",       busy,           1'b0);
    check("reset.rb_valid",   ifc.rb_valid,   1'b0);
    check("reset.rb_we",      ifc.rb_we,      1'b0);
    check("reset.rb_addr",    ifc.rb_addr,    4'd0);
    check("reset.rb_wdata",   ifc.rb_wdata,   32'd0);
    check("reset.req_grant",  ifc.req_grant,  3'b000);
    check("reset.resp_valid", ifc.resp_valid, 3'b000);
    check("reset.resp_data",  ifc.resp_data,  32'd0);
    check("reset.resp_err",   ifc.resp_err,   1'b0);

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Round-robin with everybody requesting and the bank answering at once;
    // rb_ready also sits high through IDLE and RESP, where it must be ignored.
    ifc.req_valid = 3'b111;
    ifc.req_we    = 3'b000;
    ifc.rb_ready  = 1'b1;
    exp_i = 0;
    last  = 0;
    cyc   = 0;
    for (int k = 0; k < 6; k++) begin
      ifc.rb_rdata = 32'hC0DE0000 + k;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(posedge clk); #1;
        cyc++;
        if (ifc.req_grant != '0) got = 1'b1;
      end
      check($sformatf("rr%0d.grant", k), ifc.req_grant, 3'b001 << exp_i);
      if (k > 0) check($sformatf("rr%0d.period", k), cyc - last, 3);
      last = cyc;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(posedge clk); #1;
        cyc++;
        if (ifc.resp_valid != '0) got = 1'b1;
      end
      check($sformatf("rr%0d.resp_valid", k), ifc.resp_valid, 3'b001 << exp_i);
      check($sformatf("rr%0d.resp_data", k), ifc.resp_data, 32'hC0DE0000 + k);
      exp_i = (exp_i + 1) % N;
    end
    idle_inputs();
    @(posedge clk); #1;

    // Move the pointer to 1, then reset in the middle of a BUSY phase.
    v = '{3'b001, 3'b000, 12'h001, 96'h0, 0, 32'h13579BDF, 1'b0,
          3'b001, 4'd1, 1'b0, 32'h0, 32'h13579BDF, 1'b0};
    run_txn("pre_reset", v);
    ifc.req_valid = 3'b010;
    ifc.req_addr  = 12'h040;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      if (ifc.req_grant != '0) got = 1'b1;
    end
    check("midrst.grant", ifc.req_grant, 3'b010);
    reset = 1'b1;
    ifc.rb_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.rb_valid",   ifc.rb_valid,   1'b0);
    check("midrst.busy",       busy,           1'b0);
    check("midrst.resp_valid", ifc.resp_valid, 3'b000);
    // Pointer back at 0: requester 0 beats requester 2.
    v = '{3'b101, 3'b000, 12'h20C, 96'h0, 1, 32'h2468ACE0, 1'b0,
          3'b001, 4'hC, 1'b0, 32'h0, 32'h2468ACE0, 1'b0};
    run_txn("post_reset", v);

    // Requester 1 drops req_valid right after its grant; still answered.
    v = '{3'b010, 3'b000, 12'h0B0, 96'h0, 1, 32'h600DF00D, 1'b1,
          3'b010, 4'hB, 1'b0, 32'h0, 32'h600DF00D, 1'b0};
    run_txn("early_drop", v);

    // rb_ready with nothing in flight does nothing.
    ifc.rb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready.busy",       busy,           1'b0);
    check("idle_ready.resp_valid", ifc.resp_valid, 3'b000);
    ifc.rb_ready = 1'b0;

    // Random transactions against a transaction-level reference model.
    do_reset();
    mptr = 0;
    for (int t = 0; t < 40; t++) begin
      v.rv    = 3'($urandom_range(1, 7));
      v.we    = 3'($urandom);
      v.addr  = 12'($urandom);
      v.wdata = {$urandom, $urandom, $urandom};
      v.delay = $urandom_range(0, 6);
      v.rdata = $urandom;
      v.drop  = 1'($urandom);
      idx = -1;
      for (int k = 0; k < N; k++) begin
        sc = (mptr + k) % N;
        if (idx < 0 && v.rv[sc]) idx = sc;
      end
      v.e_grant = 3'b001 << idx;
      v.e_addr  = v.addr[idx*AW +: AW];
      v.e_we    = v.we[idx];
      v.e_wdata = v.wdata[idx*DW +: DW];
      v.e_err   = (v.delay >= TO);
      v.e_data  = (v.e_we || v.e_err) ? 32'h0 : v.rdata;
      run_txn($sformatf("rand%0d", t), v);
      mptr = (idx + 1) % N;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
